inst_prefetch_unit: RTL and testbench

//  Parametrised instruction-fetch front end for the multicycle RISC-V core. Up to MAX_OUTSTANDING requests
//  run on the Inst_Req/Inst channels; in-order responses are buffered with their PC in a FIFO_DEPTH queue.
//  On redirect (branch/jump) the queue is flushed and in-flight responses are discarded.
//  The core consumes {out_pc,out_inst} with a valid/ready handshake.

---
 rtl/inst_prefetch_unit_pkg.sv | 20 ++
 rtl/inst_prefetch_unit_fifo.sv | 63 ++++++
 rtl/inst_prefetch_unit.sv | 170 +++++++++++++++++
 tb/tb_inst_prefetch_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_prefetch_unit_pkg.sv
// ============================================================================
// inst_prefetch_unit_pkg : shared encodings and constants for the fetch front end
// Rev 1.0
// ============================================================================
`default_nettype none

package inst_prefetch_unit_pkg;

    typedef enum logic [2:0] {
        FS_RST  = 3'b001,
        FS_IDLE = 3'b010,
        FS_REQ  = 3'b100
    } fetch_state_e;

    localparam int INST_W  = 32;
    localparam int PC_STEP = 4;

endpackage

`default_nettype wire

// File: rtl/inst_prefetch_unit_fifo.sv
// ============================================================================
// inst_fifo : synchronous queue of {pc, instruction}; flush beats push and pop
// Rev 1.0
// ============================================================================
`default_nettype none

module inst_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    // A full queue only takes a push when the head leaves in the same cycle.
    assign w_do_push = push && !flush && (!full || pop);
    assign w_do_pop  = pop && !flush && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/inst_prefetch_unit.sv
// ============================================================================
// inst_prefetch_unit : credit-limited instruction fetch with redirect flush
// Rev 1.0
// ============================================================================
`default_nettype none

module inst_prefetch_unit
    import inst_prefetch_unit_pkg::*;
#(
    parameter int                ADDR_W          = 32,
    parameter int                DATA_W          = INST_W,
    parameter int                FIFO_DEPTH      = 4,
    parameter int                MAX_OUTSTANDING = 2,
    parameter logic [ADDR_W-1:0] RESET_PC        = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] PC,
    output logic              Inst_Req_Valid,
    input  logic              Inst_Req_Ready,
    input  logic [DATA_W-1:0] Instruction,
    input  logic              Inst_Valid,
    output logic              Inst_Ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic [31:0]       perf_req_cnt,
    output logic [31:0]       perf_drop_cnt
);

    localparam int OSD_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int QW    = ADDR_W + DATA_W;

    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_resp_pc;
    logic [ADDR_W-1:0] r_redir_pc;
    logic              r_pend;
    logic [OSD_W-1:0]  r_osd;
    logic [OSD_W-1:0]  r_stale;
    logic [31:0]       r_perf_req;
    logic [31:0]       r_perf_drop;

    logic              w_acc;
    logic              w_resp;
    logic              w_drop;
    logic              w_push;
    logic              w_pop;
    logic              w_fifo_push;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CNT_W-1:0]  w_fifo_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [OSD_W-1:0]  w_osd_nxt;
    logic [OSD_W-1:0]  w_stale_nxt;
    logic              w_credit;
    logic [ADDR_W-1:0] w_redir_pc;
    logic [QW-1:0]     w_head;

    assign w_redir_pc  = redirect_pc & ~ADDR_W'(3);
    assign w_acc       = Inst_Req_Valid && Inst_Req_Ready;
    assign w_resp      = Inst_Valid && Inst_Ready;
    assign w_drop      = w_resp && (redirect_valid || (r_stale != '0));
    assign w_push      = w_resp && !w_drop;
    assign w_pop       = !w_fifo_empty && out_ready && !redirect_valid;
    assign w_fifo_push = w_push && (!w_fifo_full || w_pop);

    // Credit is judged on next-cycle occupancy so a steady stream never bubbles.
    assign w_osd_nxt   = r_osd + OSD_W'(w_acc) - OSD_W'(w_resp);
    assign w_cnt_nxt   = redirect_valid ? '0 : (w_fifo_cnt + CNT_W'(w_fifo_push) - CNT_W'(w_pop));
    assign w_credit    = ((int'(w_osd_nxt) + int'(w_cnt_nxt)) < FIFO_DEPTH) &&
                         (int'(w_osd_nxt) < MAX_OUTSTANDING);
    assign w_stale_nxt = r_stale - OSD_W'(w_drop) + OSD_W'(w_acc && r_pend);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= FS_RST;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        Inst_Req_Valid = 1'b0;
        Inst_Ready     = 1'b0;
        case (r_state)
            FS_RST: begin
                w_state_nxt = FS_IDLE;
            end
            FS_IDLE: begin
                Inst_Ready = 1'b1;
                if (w_credit && !redirect_valid) w_state_nxt = FS_REQ;
            end
            FS_REQ: begin
                Inst_Ready     = 1'b1;
                Inst_Req_Valid = 1'b1;
                if (Inst_Req_Ready)
                    w_state_nxt = (w_credit && !redirect_valid) ? FS_REQ : FS_IDLE;
            end
            default: begin
                w_state_nxt = FS_RST;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc  <= RESET_PC;
            r_resp_pc   <= RESET_PC;
            r_redir_pc  <= RESET_PC;
            r_pend      <= 1'b0;
            r_osd       <= '0;
            r_stale     <= '0;
            r_perf_req  <= '0;
            r_perf_drop <= '0;
        end else begin
            r_osd <= w_osd_nxt;
            if (w_acc)  r_perf_req  <= r_perf_req + 32'd1;
            if (w_drop) r_perf_drop <= r_perf_drop + 32'd1;
            if (redirect_valid) begin
                r_stale   <= w_osd_nxt;
                r_resp_pc <= w_redir_pc;
                // A presented request must not change address, so park the target.
                if ((r_state == FS_REQ) && !w_acc) begin
                    r_pend     <= 1'b1;
                    r_redir_pc <= w_redir_pc;
                end else begin
                    r_pend     <= 1'b0;
                    r_fetch_pc <= w_redir_pc;
                end
            end else begin
                r_stale <= w_stale_nxt;
                if (w_push) r_resp_pc <= r_resp_pc + ADDR_W'(PC_STEP);
                if (w_acc) begin
                    r_pend     <= 1'b0;
                    r_fetch_pc <= r_pend ? r_redir_pc : (r_fetch_pc + ADDR_W'(PC_STEP));
                end
            end
        end
    end

    inst_fifo #(
        .WIDTH (QW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_fifo_push),
        .pop   (w_pop),
        .flush (redirect_valid),
        .din   ({r_resp_pc, Instruction}),
        .dout  (w_head),
        .count (w_fifo_cnt),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign PC            = (r_state == FS_RST) ? '0 : r_fetch_pc;
    assign out_valid     = !w_fifo_empty;
    assign out_pc        = w_fifo_empty ? '0 : w_head[QW-1 -: ADDR_W];
    assign out_inst      = w_fifo_empty ? '0 : w_head[DATA_W-1:0];
    assign perf_req_cnt  = r_perf_req;
    assign perf_drop_cnt = r_perf_drop;

endmodule

`default_nettype wire

// File: tb/tb_inst_prefetch_unit.sv
// ============================================================================
// tb_inst_prefetch_unit : directed checks of fetch, backpressure, redirect, reset
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_inst_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] PC;
    logic        Inst_Req_Valid;
    logic        Inst_Req_Ready = 1'b0;
    logic [31:0] Instruction = '0;
    logic        Inst_Valid = 1'b0;
    logic        Inst_Ready;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] perf_req_cnt;
    logic [31:0] perf_drop_cnt;

    int          checks = 0;
    int          errors = 0;
    logic        resp_en = 1'b0;
    logic [31:0] mem_q[$];
    logic [31:0] acc_q[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_inst[$];

    inst_prefetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .PC             (PC),
        .Inst_Req_Valid (Inst_Req_Valid),
        .Inst_Req_Ready (Inst_Req_Ready),
        .Instruction    (Instruction),
        .Inst_Valid     (Inst_Valid),
        .Inst_Ready     (Inst_Ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .perf_req_cnt   (perf_req_cnt),
        .perf_drop_cnt  (perf_drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_acc(input int n, input int budget);
        int i = 0;
        while (acc_q.size() < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk($sformatf("wait_acc_%0d", n), 32'(acc_q.size() >= n), 32'd1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        mem_q.delete(); acc_q.delete(); pop_pc.delete(); pop_inst.delete();
        Inst_Req_Ready = 1'b0; resp_en = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Handshakes are logged 1 ns before the edge that completes them.
    initial forever begin
        @(negedge clk);
        #4;
        if (rst) begin
            if (Inst_Valid && Inst_Ready) void'(mem_q.pop_front());
            if (Inst_Req_Valid && Inst_Req_Ready) begin
                mem_q.push_back(PC);
                acc_q.push_back(PC);
            end
            if (out_valid && out_ready && !redirect_valid) begin
                pop_pc.push_back(out_pc);
                pop_inst.push_back(out_inst);
            end
        end
    end

    // One-cycle in-order memory: answers the oldest accepted request each cycle.
    initial forever begin
        @(negedge clk);
        if (rst && resp_en && mem_q.size() > 0) begin
            Inst_Valid  = 1'b1;
            Instruction = mem_data(mem_q[0]);
        end else begin
            Inst_Valid  = 1'b0;
            Instruction = '0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset values, then streaming fetch
        #1 rst = 1'b0;
        #1;
        chk("rst_pc", PC, 32'h0);
        chk("rst_req_valid", 32'(Inst_Req_Valid), 32'd0);
        chk("rst_inst_ready", 32'(Inst_Ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_perf_req", perf_req_cnt, 32'd0);
        chk("rst_perf_drop", perf_drop_cnt, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        Inst_Req_Ready = 1'b1; resp_en = 1'b1; out_ready = 1'b1;
        repeat (12) @(negedge clk);
        Inst_Req_Ready = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk($sformatf("t1_acc_pc%0d", i), qget(acc_q, i), 32'(4 * i));
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t1_pop_pc%0d", i), qget(pop_pc, i), 32'(4 * i));
            chk($sformatf("t1_pop_inst%0d", i), qget(pop_inst, i), mem_data(32'(4 * i)));
        end
        chk("t1_perf_req", perf_req_cnt, 32'(acc_q.size()));
        chk("t1_all_popped", 32'(pop_pc.size()), 32'(acc_q.size()));

        // 2: consumer stalled, queue fills to exactly FIFO_DEPTH
        apply_reset();
        Inst_Req_Ready = 1'b1; resp_en = 1'b1; out_ready = 1'b0;
        repeat (15) @(negedge clk);
        chk("t2_acc_cnt", 32'(acc_q.size()), 32'd4);
        chk("t2_req_valid", 32'(Inst_Req_Valid), 32'd0);
        chk("t2_perf_req", perf_req_cnt, 32'd4);
        chk("t2_out_pc", out_pc, 32'h0);
        chk("t2_out_inst", out_inst, 32'hDEAD_0000);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        repeat (10) @(negedge clk);
        chk("t2_acc_after_pop", 32'(acc_q.size()), 32'd5);
        chk("t2_acc_pc4", qget(acc_q, 4), 32'h10);
        chk("t2_req_valid2", 32'(Inst_Req_Valid), 32'd0);
        chk("t2_head_after_pop", out_pc, 32'h4);

        // 3: two in flight, redirect drops both
        apply_reset();
        Inst_Req_Ready = 1'b1; resp_en = 1'b0; out_ready = 1'b1;
        wait_acc(2, 20);
        repeat (2) @(negedge clk);
        chk("t3_osd_limit", 32'(Inst_Req_Valid), 32'd0);
        chk("t3_acc_cnt", 32'(acc_q.size()), 32'd2);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        redirect_valid = 1'b0; resp_en = 1'b1;
        repeat (12) @(negedge clk);
        chk("t3_drop_cnt", perf_drop_cnt, 32'd2);
        chk("t3_acc_pc2", qget(acc_q, 2), 32'h100);
        chk("t3_pop_pc0", qget(pop_pc, 0), 32'h100);
        chk("t3_pop_inst0", qget(pop_inst, 0), 32'hDEAD_0100);
        chk("t3_pop_pc1", qget(pop_pc, 1), 32'h104);

        // 4: redirect while request at 0x8 is stalled
        apply_reset();
        Inst_Req_Ready = 1'b1; resp_en = 1'b1; out_ready = 1'b1;
        wait_acc(2, 20);
        Inst_Req_Ready = 1'b0;
        @(negedge clk);
        chk("t4_pc_before", PC, 32'h8);
        chk("t4_valid_before", 32'(Inst_Req_Valid), 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t4_pc_hold%0d", i), PC, 32'h8);
            chk($sformatf("t4_valid_hold%0d", i), 32'(Inst_Req_Valid), 32'd1);
            if (i < 2) @(negedge clk);
        end
        Inst_Req_Ready = 1'b1;
        wait_acc(4, 20);
        chk("t4_acc_pc2", qget(acc_q, 2), 32'h8);
        chk("t4_acc_pc3", qget(acc_q, 3), 32'h200);
        repeat (8) @(negedge clk);
        chk("t4_drop_cnt", perf_drop_cnt, 32'd1);
        chk("t4_pop_pc0", qget(pop_pc, 0), 32'h0);
        chk("t4_pop_pc1", qget(pop_pc, 1), 32'h200);

        // 5: redirect with same-cycle push and pop, misaligned target
        apply_reset();
        Inst_Req_Ready = 1'b1; resp_en = 1'b1; out_ready = 1'b0;
        wait_acc(4, 20);
        Inst_Req_Ready = 1'b0;
        chk("t5_out_valid_pre", 32'(out_valid), 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h203; out_ready = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0; out_ready = 1'b0;
        chk("t5_out_valid_post", 32'(out_valid), 32'd0);
        chk("t5_no_pop", 32'(pop_pc.size()), 32'd0);
        Inst_Req_Ready = 1'b1;
        wait_acc(5, 20);
        chk("t5_next_pc", qget(acc_q, 4), 32'h200);
        repeat (4) @(negedge clk);
        chk("t5_head_pc", out_pc, 32'h200);
        chk("t5_head_inst", out_inst, 32'hDEAD_0200);

        // 6: async reset mid-burst
        apply_reset();
        Inst_Req_Ready = 1'b1; resp_en = 1'b1; out_ready = 1'b0;
        wait_acc(4, 20);
        #2 rst = 1'b0;
        #1;
        chk("t6_pc", PC, 32'h0);
        chk("t6_req_valid", 32'(Inst_Req_Valid), 32'd0);
        chk("t6_inst_ready", 32'(Inst_Ready), 32'd0);
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_out_pc", out_pc, 32'h0);
        chk("t6_out_inst", out_inst, 32'h0);
        chk("t6_perf_req", perf_req_cnt, 32'd0);
        chk("t6_perf_drop", perf_drop_cnt, 32'd0);
        mem_q.delete(); acc_q.delete(); pop_pc.delete(); pop_inst.delete();
        Inst_Req_Ready = 1'b0; resp_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_pc_after", PC, 32'h0);
        Inst_Req_Ready = 1'b1; resp_en = 1'b1; out_ready = 1'b1;
        wait_acc(1, 20);
        chk("t6_first_acc", qget(acc_q, 0), 32'h0);
        chk("t6_perf_req_after", perf_req_cnt, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
